// File: rtl/f_event_counter.sv
// f_event_counter: synchronises F, rejects short glitches, and counts each qualified rising edge.
module f_event_counter #(
  parameter int CNT_W    = 8,
  parameter int MIN_HIGH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             event_pulse,
  output logic             f_level,
  output logic             overflow
);
  localparam int QW = $clog2(MIN_HIGH + 1);
  typedef enum logic [1:0] {IDLE, QUAL, HIGH} state_t;
  state_t state, nxt;
  logic s1, f_s, fire;
  logic [QW-1:0] qcnt, qnxt;
  wire cnt_max = &count;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      f_s   <= 1'b0;
      state <= IDLE;
      qcnt  <= '0;
    end else begin
      s1    <= f_in;
      f_s   <= s1;
      state <= nxt;
      qcnt  <= qnxt;
    end
  end
  always_comb begin
    nxt  = state;
    qnxt = qcnt;
    fire = 1'b0;
    case (state)
      IDLE: if (f_s) begin
        qnxt = QW'(1);
        nxt  = (MIN_HIGH == 1) ? HIGH : QUAL;
        fire = (MIN_HIGH == 1);
      end
      QUAL: if (!f_s) nxt = IDLE;
        else if (qcnt == QW'(MIN_HIGH - 1)) begin
          nxt  = HIGH;
          fire = 1'b1;
        end else qnxt = qcnt + QW'(1);
      HIGH: nxt = f_s ? HIGH : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb f_level = (state == HIGH);
  // A clear coinciding with an event restarts the count at one so the event is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      overflow    <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= fire;
      if (fire) begin
        count    <= clr ? CNT_W'(1) : (cnt_max ? count : count + CNT_W'(1));
        overflow <= clr ? 1'b0 : (overflow | cnt_max);
      end else if (clr) begin
        count    <= '0;
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_f_event_counter.sv
// tb_f_event_counter: scoreboard bench; stimulus queues expected events, monitor checks each event_pulse.
module tb_f_event_counter;
  logic clk = 1'b0, rst = 1'b1, f_in = 1'b0, clr = 1'b0;
  logic [1:0] count;
  logic event_pulse, f_level, overflow;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct { int cyc; int cnt; int ov; } exp_t;
  exp_t q[$];

  f_event_counter #(.CNT_W(2), .MIN_HIGH(3)) dut (
    .clk(clk), .rst(rst), .f_in(f_in), .clr(clr),
    .count(count), .event_pulse(event_pulse), .f_level(f_level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Qualified pulses fire on the fifth edge after f_in rises (first sample plus four).
  task automatic pulse(input int len, input int ecnt = -1, input int eov = 0);
    f_in = 1'b1;
    if (ecnt >= 0) q.push_back('{cyc + 5, ecnt, eov});
    tick(len);
    f_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (event_pulse) begin
      if (q.size() == 0) chk("unexpected_event_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_count", int'(count), e.cnt);
        chk("event_overflow", int'(overflow), e.ov);
      end
    end
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(10);
    chk("idle_count", int'(count), 0);
    chk("idle_overflow", int'(overflow), 0);
    chk("idle_level", int'(f_level), 0);
    pulse(5, 1, 0);
    chk("level_rise", int'(f_level), 1);
    tick(2);
    chk("level_hold", int'(f_level), 1);
    tick();
    chk("level_fall", int'(f_level), 0);
    tick(6);
    pulse(1);
    tick(4);
    chk("glitch1_level", int'(f_level), 0);
    pulse(2);
    tick(1);
    chk("glitch2_level", int'(f_level), 0);
    tick(6);
    chk("glitch_count", int'(count), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", int'(count), 0);
    for (int i = 0; i < 5; i++) begin
      pulse(3, (i < 3) ? i + 1 : 3, (i >= 3) ? 1 : 0);
      tick(6);
    end
    chk("sat_count", int'(count), 3);
    chk("sat_overflow", int'(overflow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_count", int'(count), 0);
    chk("clr2_overflow", int'(overflow), 0);
    pulse(3, 1, 0);
    tick(6);
    pulse(3, 2, 0);
    tick(6);
    f_in = 1'b1;
    q.push_back('{cyc + 5, 1, 0});
    tick(4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_event_count", int'(count), 1);
    chk("clr_event_pulse", int'(event_pulse), 1);
    f_in = 1'b0;
    tick(6);
    f_in = 1'b1;
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {count, event_pulse, f_level, overflow}, 0);
    end
    rst = 1'b0;
    q.push_back('{cyc + 5, 1, 0});
    tick(4);
    chk("post_rst_pending", int'(event_pulse), 0);
    tick();
    chk("post_rst_level", int'(f_level), 1);
    f_in = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
